// File: rtl/arbitro_prioridade_display.sv
// arbitro_prioridade_display
//
// Registered arbitration core for the two-operator control panel. It does three things:
//   - ranks the two operator user codes;
//   - compares the two permission-filtered function codes;
//   - drives the output-select, the autopilot flag and the losing user's code.
// The losing code is also decoded onto one active-low 7-segment digit.
// All outputs come from a single register stage (1-clock latency).
//
// Build option:
//   AUTOPILOT_EN  defined   -> code 111 ranks 3 (autopilot), autopilot_o is live
//                 undefined -> code 111 ranks 0 (invalid), autopilot_o is tied 0
//
// Ports:
//   clk          system clock, rising-edge
//   rst          synchronous active-high reset
//   user0_i/1_i  3-bit user codes for operator 0 / 1
//   func0_i/1_i  3-bit permission-filtered function codes (000 = neutral)
//   disp_en_i    1 = show the loser digit, 0 = blank display
//   sel_o        00 none, 01 operator 0, 10 operator 1, 11 both
//   eq_o         function codes are equal
//   autopilot_o  both users are autopilot
//   loser_o      lower-priority user code
//   seg_o        active-low segments {dp,g,f,e,d,c,b,a}

module arbitro_prioridade_display (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] user0_i,
    input  logic [2:0] user1_i,
    input  logic [2:0] func0_i,
    input  logic [2:0] func1_i,
    input  logic       disp_en_i,
    output logic [1:0] sel_o,
    output logic       eq_o,
    output logic       autopilot_o,
    output logic [2:0] loser_o,
    output logic [7:0] seg_o
);

    typedef struct packed {
        logic [1:0] sel;
        logic       eq;
        logic       autopilot;
        logic [2:0] loser;
        logic [7:0] seg;
    } arb_out_t;

    localparam arb_out_t RESET_VAL = '{sel: 2'b00, eq: 1'b0, autopilot: 1'b0,
                                       loser: 3'b000, seg: 8'hFF};

    function automatic logic [1:0] rank(input logic [2:0] code);
        unique case (code)
`ifdef AUTOPILOT_EN
            3'b111:                 rank = 2'd3;
`else
            3'b111:                 rank = 2'd0;
`endif
            3'b101:                 rank = 2'd2;
            3'b001, 3'b011, 3'b110: rank = 2'd1;
            default:                rank = 2'd0;
        endcase
    endfunction

    function automatic logic [7:0] seg_decode(input logic [2:0] digit);
        unique case (digit)
            3'd0: seg_decode = 8'hC0;
            3'd1: seg_decode = 8'hF9;
            3'd2: seg_decode = 8'hA4;
            3'd3: seg_decode = 8'hB0;
            3'd4: seg_decode = 8'h99;
            3'd5: seg_decode = 8'h92;
            3'd6: seg_decode = 8'h82;
            default: seg_decode = 8'hF8;
        endcase
    endfunction

    logic [1:0] rank0, rank1;
    logic [1:0] prio;
    arb_out_t   nxt, q;

    always_comb begin
        rank0 = rank(user0_i);
        rank1 = rank(user1_i);

        // Both-autopilot reports 11. Both-invalid reports 00.
        // Otherwise the higher rank wins, and operator 0 takes ties.
        // Rank 3 can only be equal at 3, so prio 11 never appears without AUTOPILOT_EN.
        if (rank0 == 2'd3 && rank1 == 2'd3)
            prio = 2'b11;
        else if (rank0 == 2'd0 && rank1 == 2'd0)
            prio = 2'b00;
        else if (rank1 > rank0)
            prio = 2'b10;
        else
            prio = 2'b01;

        nxt           = RESET_VAL;
        nxt.eq        = (func0_i == func1_i);
        // Differing functions run on both sides; decoders blank invalid users.
        nxt.sel       = nxt.eq ? prio : 2'b11;
        nxt.autopilot = (prio == 2'b11);

        unique case (prio)
            2'b01:   nxt.loser = user1_i;
            2'b10:   nxt.loser = user0_i;
            2'b11:   nxt.loser = user1_i;
            default: nxt.loser = 3'b000;
        endcase

        nxt.seg = disp_en_i ? seg_decode(nxt.loser) : 8'hFF;
    end

    always_ff @(posedge clk) begin
        if (rst)
            q <= RESET_VAL;
        else
            q <= nxt;
    end

    assign sel_o       = q.sel;
    assign eq_o        = q.eq;
    assign autopilot_o = q.autopilot;
    assign loser_o     = q.loser;
    assign seg_o       = q.seg;

endmodule

// File: tb/tb_arbitro_prioridade_display.sv
// Directed-vector bench for arbitro_prioridade_display.
// Expectations are hand-computed; the AUTOPILOT_EN-dependent cases switch on the macro.
module tb_arbitro_prioridade_display;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] user0_i, user1_i, func0_i, func1_i;
    logic       disp_en_i;
    logic [1:0] sel_o;
    logic       eq_o, autopilot_o;
    logic [2:0] loser_o;
    logic [7:0] seg_o;

    int n_cmp = 0;
    int n_err = 0;

    arbitro_prioridade_display dut (
        .clk         (clk),
        .rst         (rst),
        .user0_i     (user0_i),
        .user1_i     (user1_i),
        .func0_i     (func0_i),
        .func1_i     (func1_i),
        .disp_en_i   (disp_en_i),
        .sel_o       (sel_o),
        .eq_o        (eq_o),
        .autopilot_o (autopilot_o),
        .loser_o     (loser_o),
        .seg_o       (seg_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [2:0] u0, input logic [2:0] u1,
                         input logic [2:0] f0, input logic [2:0] f1, input logic en);
        user0_i = u0; user1_i = u1; func0_i = f0; func1_i = f1; disp_en_i = en;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_all(input string tag, input logic [1:0] sel, input logic eq,
                              input logic ap, input logic [2:0] los, input logic [7:0] seg);
        chk({tag, ".sel"},   {6'd0, sel_o},       {6'd0, sel});
        chk({tag, ".eq"},    {7'd0, eq_o},        {7'd0, eq});
        chk({tag, ".ap"},    {7'd0, autopilot_o}, {7'd0, ap});
        chk({tag, ".loser"}, {5'd0, loser_o},     {5'd0, los});
        chk({tag, ".seg"},   seg_o,               seg);
    endtask

    initial begin
        rst = 1'b1;
        drive(3'b101, 3'b001, 3'b010, 3'b001, 1'b1);
        expect_all("reset", 2'b00, 1'b0, 1'b0, 3'b000, 8'hFF);
        rst = 1'b0;

        // Admin beats user, functions equal.
        drive(3'b101, 3'b001, 3'b001, 3'b001, 1'b1);
        expect_all("adm_vs_usr", 2'b01, 1'b1, 1'b0, 3'b001, 8'hF9);

        // Functions differ: both sides run.
        drive(3'b101, 3'b001, 3'b010, 3'b001, 1'b1);
        expect_all("func_diff", 2'b11, 1'b0, 1'b0, 3'b001, 8'hF9);

        // Both autopilot.
        drive(3'b111, 3'b111, 3'b101, 3'b101, 1'b1);
`ifdef AUTOPILOT_EN
        expect_all("both_ap", 2'b11, 1'b1, 1'b1, 3'b111, 8'hF8);
`else
        expect_all("both_ap", 2'b00, 1'b1, 1'b0, 3'b000, 8'hC0);
`endif

        // User vs invalid, display blanked.
        drive(3'b001, 3'b100, 3'b001, 3'b001, 1'b0);
        expect_all("usr_inv_blank", 2'b01, 1'b1, 1'b0, 3'b100, 8'hFF);
        drive(3'b001, 3'b100, 3'b001, 3'b001, 1'b1);
        expect_all("usr_inv_show", 2'b01, 1'b1, 1'b0, 3'b100, 8'h99);

        // Operator 1 wins on rank.
        drive(3'b011, 3'b101, 3'b011, 3'b011, 1'b1);
        expect_all("op1_wins", 2'b10, 1'b1, 1'b0, 3'b011, 8'hB0);

        // Equal user rank: operator 0 takes the tie.
        drive(3'b110, 3'b011, 3'b000, 3'b000, 1'b1);
        expect_all("tie_usr", 2'b01, 1'b1, 1'b0, 3'b011, 8'hB0);

        // Autopilot vs admin.
        drive(3'b111, 3'b101, 3'b100, 3'b100, 1'b1);
`ifdef AUTOPILOT_EN
        expect_all("ap_vs_adm", 2'b01, 1'b1, 1'b0, 3'b101, 8'h92);
`else
        expect_all("ap_vs_adm", 2'b10, 1'b1, 1'b0, 3'b111, 8'hF8);
`endif

        // Admin vs autopilot, functions differ.
        drive(3'b101, 3'b111, 3'b110, 3'b011, 1'b1);
`ifdef AUTOPILOT_EN
        expect_all("adm_vs_ap", 2'b11, 1'b0, 1'b0, 3'b101, 8'h92);
`else
        expect_all("adm_vs_ap", 2'b11, 1'b0, 1'b0, 3'b111, 8'hF8);
`endif

        // Both invalid.
        drive(3'b000, 3'b010, 3'b011, 3'b011, 1'b1);
        expect_all("both_inv", 2'b00, 1'b1, 1'b0, 3'b000, 8'hC0);

        // Reset mid-stream with non-trivial inputs present.
        rst = 1'b1;
        drive(3'b101, 3'b110, 3'b001, 3'b001, 1'b1);
        expect_all("mid_reset", 2'b00, 1'b0, 1'b0, 3'b000, 8'hFF);
        rst = 1'b0;
        drive(3'b101, 3'b110, 3'b001, 3'b001, 1'b1);
        expect_all("recover", 2'b01, 1'b1, 1'b0, 3'b110, 8'h82);

        // Neutral function on both sides, display of digit 2.
        drive(3'b010, 3'b001, 3'b000, 3'b000, 1'b1);
        expect_all("digit2", 2'b10, 1'b1, 1'b0, 3'b010, 8'hA4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
